keypad_operand_entry: RTL
=========================

Name: keypad_operand_entry

Overview:
- Consumes the key events produced by the keypad scanner (`new_key`, `new_key_char`).
- Assembles two 16-bit half-precision operands from hexadecimal keystrokes.
- Presents the pair to the FP adder datapath over a valid/ready handshake.
- Acts as the writer side for the adder's operand inputs and exposes a live entry word and stage for display/LEDs.

Parameters:
- NUM_DIGITS, 4, hex digits per operand.
- WORD_W, 16, operand width; must equal 4*NUM_DIGITS.

Ports:
- clk  input  1  system clock (scanner clock domain).
- reset_n  input  1  asynchronous, active-low reset.
- new_key  input  1  key-event flag from the scanner; may stay high for more than one cycle.
- new_key_char  input  4  scanner key index, valid while new_key is high.
- pair_ready  input  1  adder accepts the operand pair.
- pair_valid  output  1  op_a/op_b hold a complete pair.
- op_a  output  WORD_W  first operand.
- op_b  output  WORD_W  second operand.
- entry_word  output  WORD_W  operand currently being typed, right-aligned.
- digit_count  output  3  digits in entry_word, range 0..NUM_DIGITS.
- stage  output  2  00 ENTER_A, 01 ENTER_B, 10 PRESENT.
- shift_armed  output  1  shift modifier is pending.
- key_err  output  1  one-cycle pulse when a keystroke is rejected.

Behaviour:
- Reset (async, reset_n=0): every output is 0, the FSM is in ENTER_A, and the edge-detect register is 0. Reset mid-entry or mid-handshake discards everything.
- Key acceptance:
  - new_key is registered into new_key_q.
  - A key is accepted only on a cycle with new_key=1 and new_key_q=0.
  - A held key is therefore taken exactly once.
  - The effect of an accepted key is visible on the outputs on the next clk edge (latency 1).
- Key map (scanner index -> meaning):
  - Digits: 0='1', 1='2', 2='3', 3='A', 4='4', 5='5', 6='6', 7='B', 8='7', 9='8', 10='9', 11='C', 13='0', 15='D'.
  - Index 12 ('*') is SHIFT; index 14 ('#') is ENTER.
- Shift (one-shot):
  - '*' sets shift_armed. '*' while already armed clears it.
  - With shift armed: A->hex E, B->hex F, C->BACKSPACE, D->CLEAR.
  - Any other key behaves unshifted.
  - Any non-'*' accepted key clears shift_armed.
- Digit: if digit_count<NUM_DIGITS then entry_word <= {entry_word[WORD_W-5:0], nibble} and digit_count+1. Otherwise the word is unchanged and key_err pulses.
- BACKSPACE:
  - If digit_count>0: entry_word <= entry_word>>4 and digit_count-1.
  - At 0: no-op, no error.
- CLEAR: entry_word=0, digit_count=0.
- ENTER:
  - digit_count==0: key_err pulses and the state is unchanged.
  - Otherwise the operand is zero-extended (value as typed). entry_word and digit_count clear.
  - In ENTER_A: op_a <= entry_word and go to ENTER_B.
  - In ENTER_B: op_b <= entry_word and go to PRESENT; pair_valid is 1 from the next cycle.
- PRESENT:
  - pair_valid=1, and op_a/op_b are held stable.
  - Every accepted key is dropped with a key_err pulse; shift is unaffected.
  - pair_valid & pair_ready at a clk edge: pair_valid=0 next cycle, go to ENTER_A. op_a/op_b retain their values until overwritten.
- Simultaneous events:
  - A key edge on the same cycle as the handshake completes is evaluated in PRESENT, so it is dropped with key_err.
  - pair_ready while not PRESENT is ignored.
- key_err is never high for two consecutive cycles from a single keystroke.
- stage encoding 11 is unused. The FSM recovers from it to ENTER_A.

Decomposition:
- Shared package `keypad_pkg`:
  - key index localparams (KEY_STAR=12, KEY_HASH=14, KEY_A=3, KEY_B=7, KEY_C=11, KEY_D=15).
  - key class enum: DIGIT, SHIFT, ENTER, BKSP, CLR.
  - stage encoding constants.
- Sub-module `keypad_key_decode` (combinational): inputs key index and shift_armed; outputs key class and 4-bit nibble. It is reusable by the display path.
- The top module contains the edge detector, FSM, entry shift register and handshake.

Test Plan:
- Reset, then keys '3','C','0','0','#', then '4','0','0','0','#' -> stage walks 00->01->10; op_a=16'h3C00, op_b=16'h4000; pair_valid=1 one cycle after the second '#'.
- new_key held high for 5 cycles with index 13 -> entry_word=16'h0000 with digit_count=1 (one digit only); then '*','A','*','B' -> entry_word=16'h00EF, digit_count=3.
- Five digits '1','2','3','4','5' -> entry_word=16'h1234; key_err pulses once on the fifth; then '*','C' -> entry_word=16'h0123, digit_count=3.
- '#' with digit_count=0 -> key_err pulse, stage stays 00; in PRESENT with pair_ready=0, key '7' -> key_err, op_a/op_b unchanged; raise pair_ready -> pair_valid falls next cycle, stage=00.
- Deassert reset_n asynchronously mid-entry (entry_word=16'h0AB0, stage=01) -> all outputs 0 immediately, stage=00; first key after release is accepted normally.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for keypad operand entry: key indices, key classes, stage encoding.
// Pure declarations: no logic, no latency, no flow control.
package keypad_pkg;

    localparam logic [3:0] KEY_A    = 4'd3;
    localparam logic [3:0] KEY_B    = 4'd7;
    localparam logic [3:0] KEY_C    = 4'd11;
    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] KEY_D    = 4'd15;

    typedef enum logic [2:0] {
        KC_DIGIT,
        KC_SHIFT,
        KC_ENTER,
        KC_BKSP,
        KC_CLR
    } key_class_t;

    localparam logic [1:0] STAGE_ENTER_A = 2'b00;
    localparam logic [1:0] STAGE_ENTER_B = 2'b01;
    localparam logic [1:0] STAGE_PRESENT = 2'b10;

    typedef enum logic [1:0] {
        ENTER_A = STAGE_ENTER_A,
        ENTER_B = STAGE_ENTER_B,
        PRESENT = STAGE_PRESENT
    } stage_t;

endpackage

// File: rtl/keypad_key_decode.sv
// Maps a scanner key index plus shift state to a key class and hex nibble.
// Combinational, zero latency; no flow control.
module keypad_key_decode
    import keypad_pkg::*;
(
    input  logic [3:0]  key_idx,
    input  logic        shift_armed,
    output key_class_t  key_class,
    output logic [3:0]  nibble
);

    always_comb begin
        key_class = KC_DIGIT;
        nibble    = 4'h0;
        case (key_idx)
            4'd0:     nibble = 4'h1;
            4'd1:     nibble = 4'h2;
            4'd2:     nibble = 4'h3;
            KEY_A:    nibble = shift_armed ? 4'hE : 4'hA;
            4'd4:     nibble = 4'h4;
            4'd5:     nibble = 4'h5;
            4'd6:     nibble = 4'h6;
            KEY_B:    nibble = shift_armed ? 4'hF : 4'hB;
            4'd8:     nibble = 4'h7;
            4'd9:     nibble = 4'h8;
            4'd10:    nibble = 4'h9;
            KEY_C: begin
                if (shift_armed) key_class = KC_BKSP;
                else             nibble    = 4'hC;
            end
            KEY_STAR: key_class = KC_SHIFT;
            4'd13:    nibble = 4'h0;
            KEY_HASH: key_class = KC_ENTER;
            KEY_D: begin
                if (shift_armed) key_class = KC_CLR;
                else             nibble    = 4'hD;
            end
            default:  nibble = 4'h0;
        endcase
    end

endmodule

// File: rtl/keypad_operand_entry.sv
// Builds two hex operands from keypad events and offers them as a pair to the adder.
// Key effect visible 1 cycle after its rising edge; pair held until pair_ready, keys dropped meanwhile.
module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int WORD_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              new_key,
    input  logic [3:0]        new_key_char,
    input  logic              pair_ready,
    output logic              pair_valid,
    output logic [WORD_W-1:0] op_a,
    output logic [WORD_W-1:0] op_b,
    output logic [WORD_W-1:0] entry_word,
    output logic [2:0]        digit_count,
    output logic [1:0]        stage,
    output logic              shift_armed,
    output logic              key_err
);

    localparam logic [2:0] MAX_DIGITS = 3'(NUM_DIGITS);

    stage_t      state;
    logic        new_key_q;
    logic        key_fire;
    key_class_t  key_class;
    logic [3:0]  nibble;

    // Scanner may hold new_key for several cycles; only its rising edge counts.
    assign key_fire = new_key & ~new_key_q;
    assign stage    = state;

    keypad_key_decode u_decode (
        .key_idx     (new_key_char),
        .shift_armed (shift_armed),
        .key_class   (key_class),
        .nibble      (nibble)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ENTER_A;
            new_key_q   <= 1'b0;
            entry_word  <= '0;
            digit_count <= 3'd0;
            shift_armed <= 1'b0;
            key_err     <= 1'b0;
            pair_valid  <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
        end else begin
            new_key_q <= new_key;
            key_err   <= 1'b0;
            case (state)
                ENTER_A, ENTER_B: begin
                    if (key_fire) begin
                        shift_armed <= (key_class == KC_SHIFT) ? ~shift_armed : 1'b0;
                        case (key_class)
                            KC_DIGIT: begin
                                if (digit_count < MAX_DIGITS) begin
                                    entry_word  <= {entry_word[WORD_W-5:0], nibble};
                                    digit_count <= digit_count + 3'd1;
                                end else begin
                                    key_err <= 1'b1;
                                end
                            end
                            KC_BKSP: begin
                                if (digit_count != 3'd0) begin
                                    entry_word  <= entry_word >> 4;
                                    digit_count <= digit_count - 3'd1;
                                end
                            end
                            KC_CLR: begin
                                entry_word  <= '0;
                                digit_count <= 3'd0;
                            end
                            KC_ENTER: begin
                                if (digit_count == 3'd0) begin
                                    key_err <= 1'b1;
                                end else begin
                                    entry_word  <= '0;
                                    digit_count <= 3'd0;
                                    if (state == ENTER_A) begin
                                        op_a  <= entry_word;
                                        state <= ENTER_B;
                                    end else begin
                                        op_b       <= entry_word;
                                        state      <= PRESENT;
                                        pair_valid <= 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                PRESENT: begin
                    // Keys arriving while the pair is offered are rejected, even on the handshake cycle.
                    if (key_fire) key_err <= 1'b1;
                    if (pair_ready) begin
                        pair_valid <= 1'b0;
                        state      <= ENTER_A;
                    end
                end
                default: begin
                    state      <= ENTER_A;
                    pair_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
